// File: rtl/fp16_add_scheduler.sv
// Round-robin scheduler sharing one pipelined FP16 adder among NUM_REQ requesters, results returned tagged.
// Latency: handshake -> rsp_valid is ADD_LAT+2 cycles; one op issued per cycle.
// Backpressure: req_ready is a one-hot grant (none while draining); results cannot be stalled.
// Optional counters: define FP16_SCHED_PERF_EN to build perf_ops/perf_ovf.
module fp16_add_scheduler #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ),
    parameter int ADD_LAT = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [NUM_REQ*16-1:0]  req_a,
    input  logic [NUM_REQ*16-1:0]  req_b,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic                   add_valid,
    output logic [15:0]            add_a,
    output logic [15:0]            add_b,
    input  logic [15:0]            add_result,
    input  logic                   add_ovf,
    input  logic                   add_unf,
    output logic                   rsp_valid,
    output logic [ID_W-1:0]        rsp_id,
    output logic [15:0]            rsp_result,
    output logic [1:0]             rsp_flags,
    input  logic                   drain_req,
    output logic                   drain_done,
    output logic                   busy,
    output logic [31:0]            perf_ops,
    output logic [15:0]            perf_ovf
);

    typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_DONE} state_t;

    state_t            state_q, state_d;
    logic              run_en;
    logic [ID_W-1:0]   rr_ptr;
    logic [ID_W-1:0]   cand;
    logic [ID_W-1:0]   grant_id;
    logic              grant_vld;
    logic              hs;
    logic [ID_W-1:0]   add_id;
    logic [ADD_LAT-1:0] tag_vld;
    logic [ID_W-1:0]   tag_id [ADD_LAT];
    logic [3:0]        inflight;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_RUN;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        run_en  = 1'b0;
        unique case (state_q)
            ST_RUN: begin
                run_en = 1'b1;
                if (drain_req) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (!drain_req)          state_d = ST_RUN;
                else if (inflight == '0) state_d = ST_DONE;
            end
            ST_DONE: begin
                if (!drain_req) state_d = ST_RUN;
            end
            default: state_d = ST_RUN;
        endcase
    end

    // Search starts at rr_ptr and wraps, so the first valid hit is the fair winner.
    always_comb begin
        grant_vld = 1'b0;
        grant_id  = '0;
        cand      = '0;
        req_ready = '0;
        if (run_en) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                cand = ID_W'((int'(rr_ptr) + i) % NUM_REQ);
                if (!grant_vld && req_valid[cand]) begin
                    grant_vld = 1'b1;
                    grant_id  = cand;
                end
            end
            if (grant_vld) req_ready = NUM_REQ'(1) << grant_id;
        end
    end

    assign hs = grant_vld;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr    <= '0;
            add_valid <= 1'b0;
            add_a     <= '0;
            add_b     <= '0;
            add_id    <= '0;
        end else begin
            add_valid <= hs;
            if (hs) begin
                rr_ptr <= (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
                add_a  <= req_a[16*grant_id +: 16];
                add_b  <= req_b[16*grant_id +: 16];
                add_id <= grant_id;
            end
        end
    end

    // Owner tags ride alongside the adder so the last stage lines up with add_result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_vld <= '0;
            for (int i = 0; i < ADD_LAT; i++) tag_id[i] <= '0;
        end else begin
            tag_vld[0] <= add_valid;
            tag_id[0]  <= add_id;
            for (int i = 1; i < ADD_LAT; i++) begin
                tag_vld[i] <= tag_vld[i-1];
                tag_id[i]  <= tag_id[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid  <= 1'b0;
            rsp_id     <= '0;
            rsp_result <= '0;
            rsp_flags  <= '0;
        end else begin
            rsp_valid <= tag_vld[ADD_LAT-1];
            if (tag_vld[ADD_LAT-1]) begin
                rsp_id     <= tag_id[ADD_LAT-1];
                rsp_result <= add_result;
                rsp_flags  <= {add_ovf, add_unf};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight <= '0;
        end else begin
            unique case ({hs, rsp_valid})
                2'b10:   inflight <= inflight + 4'd1;
                2'b01:   inflight <= inflight - 4'd1;
                default: inflight <= inflight;
            endcase
        end
    end

    assign busy       = (inflight != '0);
    assign drain_done = (state_q != ST_RUN) && drain_req && (inflight == '0);

`ifdef FP16_SCHED_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_ops <= '0;
            perf_ovf <= '0;
        end else if (rsp_valid) begin
            if (perf_ops != '1)                perf_ops <= perf_ops + 32'd1;
            if (rsp_flags[1] && perf_ovf != '1) perf_ovf <= perf_ovf + 16'd1;
        end
    end
`else
    assign perf_ops = '0;
    assign perf_ovf = '0;
`endif

endmodule

// File: tb/tb_fp16_add_scheduler.sv
// Directed bench for fp16_add_scheduler with a 3-cycle registered FP16 adder model.
module tb_fp16_add_scheduler;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [63:0] req_a, req_b;
    logic [3:0]  req_ready;
    logic        add_valid;
    logic [15:0] add_a, add_b;
    logic [15:0] add_result;
    logic        add_ovf, add_unf;
    logic        rsp_valid;
    logic [1:0]  rsp_id;
    logic [15:0] rsp_result;
    logic [1:0]  rsp_flags;
    logic        drain_req;
    logic        drain_done;
    logic        busy;
    logic [31:0] perf_ops;
    logic [15:0] perf_ovf;

    int checks = 0;
    int errors = 0;

    logic [15:0] exp_res [4];
    logic [1:0]  exp_drain_id [3];
    logic [17:0] p1 = '0, p2 = '0, p3 = '0;

    always #5 clk = ~clk;

    fp16_add_scheduler #(.NUM_REQ(4), .ID_W(2), .ADD_LAT(3)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
        .add_valid(add_valid), .add_a(add_a), .add_b(add_b),
        .add_result(add_result), .add_ovf(add_ovf), .add_unf(add_unf),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_result(rsp_result), .rsp_flags(rsp_flags),
        .drain_req(drain_req), .drain_done(drain_done), .busy(busy),
        .perf_ops(perf_ops), .perf_ovf(perf_ovf)
    );

    // Exact add of same-sign normal operands (all vectors here are exact); {ovf, unf, result}.
    function automatic logic [17:0] fp16_add(input logic [15:0] a, input logic [15:0] b);
        logic [15:0] x, y;
        logic [4:0]  ea, eb;
        logic [11:0] ma, mb, sum;
        logic [5:0]  e;
        if (b[14:10] > a[14:10]) begin x = b; y = a; end
        else begin x = a; y = b; end
        ea  = x[14:10];
        eb  = y[14:10];
        ma  = {2'b01, x[9:0]};
        mb  = {2'b01, y[9:0]} >> (ea - eb);
        sum = ma + mb;
        e   = {1'b0, ea};
        if (sum[11]) begin
            sum = sum >> 1;
            e   = e + 6'd1;
        end
        if (e >= 6'd31) return {2'b10, x[15], 15'h7C00};
        return {2'b00, x[15], e[4:0], sum[9:0]};
    endfunction

    always @(posedge clk) begin
        p1 <= fp16_add(add_a, add_b);
        p2 <= p1;
        p3 <= p2;
    end
    assign add_result = p3[15:0];
    assign add_ovf    = p3[17];
    assign add_unf    = p3[16];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic [3:0] v);
        @(negedge clk);
        req_valid = v;
        #1;
    endtask

    task automatic set_op(input int i, input logic [15:0] a, input logic [15:0] b);
        req_a[16*i +: 16] = a;
        req_b[16*i +: 16] = b;
    endtask

    initial begin
        exp_res[0] = 16'h4000;
        exp_res[1] = 16'h4200;
        exp_res[2] = 16'h4400;
        exp_res[3] = 16'h3C00;
        exp_drain_id[0] = 2'd1;
        exp_drain_id[1] = 2'd2;
        exp_drain_id[2] = 2'd0;
        rst_n = 1'b1;
        req_valid = '0;
        req_a = '0;
        req_b = '0;
        drain_req = 1'b0;
        #2 rst_n = 1'b0;

        // Reset state
        step(4'b0000);
        check("rst_ready", req_ready, 0);
        check("rst_add_valid", add_valid, 0);
        check("rst_add_a", add_a, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_drain_done", drain_done, 0);
        check("rst_perf_ops", perf_ops, 0);
        check("rst_perf_ovf", perf_ovf, 0);
        rst_n = 1'b1;

        // Overflow, requester 0 at ptr 0
        set_op(0, 16'h7BFF, 16'h7BFF);
        step(4'b0001);
        check("ovf_grant", req_ready, 4'b0001);
        step(4'b0000);
        check("ovf_add_valid", add_valid, 1);
        check("ovf_add_a", add_a, 16'h7BFF);
        check("ovf_busy", busy, 1);
        repeat (3) begin
            step(4'b0000);
            check("ovf_no_rsp_yet", rsp_valid, 0);
        end
        step(4'b0000);
        check("ovf_rsp_valid", rsp_valid, 1);
        check("ovf_rsp_id", rsp_id, 0);
        check("ovf_result", rsp_result, 16'h7C00);
        check("ovf_flags", rsp_flags, 2'b10);
        step(4'b0000);
        check("ovf_rsp_pulse", rsp_valid, 0);
        check("ovf_busy_clear", busy, 0);
`ifdef FP16_SCHED_PERF_EN
        check("ovf_perf_ops", perf_ops, 1);
        check("ovf_perf_ovf", perf_ovf, 1);
`else
        check("ovf_perf_ops", perf_ops, 0);
        check("ovf_perf_ovf", perf_ovf, 0);
`endif

        // Single op, requester 1 at ptr 1
        set_op(1, 16'h3C00, 16'h4000);
        step(4'b0010);
        check("single_grant", req_ready, 4'b0010);
        step(4'b0000);
        check("single_add_valid", add_valid, 1);
        check("single_add_a", add_a, 16'h3C00);
        check("single_add_b", add_b, 16'h4000);
        repeat (3) begin
            step(4'b0000);
            check("single_no_rsp_yet", rsp_valid, 0);
        end
        step(4'b0000);
        check("single_rsp_valid", rsp_valid, 1);
        check("single_rsp_id", rsp_id, 1);
        check("single_result", rsp_result, 16'h4200);
        check("single_flags", rsp_flags, 2'b00);
        step(4'b0000);
        check("single_add_valid_low", add_valid, 0);
        check("single_add_a_hold", add_a, 16'h3C00);

        // Requester 3 moves ptr from 2 to 0
        set_op(3, 16'h3C00, 16'h3800);
        step(4'b1000);
        check("p3_grant", req_ready, 4'b1000);
        repeat (4) step(4'b0000);
        step(4'b0000);
        check("p3_rsp_id", rsp_id, 3);
        check("p3_result", rsp_result, 16'h3E00);

        // Contention from ptr 0
        set_op(0, 16'h3C00, 16'h3C00);
        set_op(1, 16'h3C00, 16'h4000);
        set_op(2, 16'h4000, 16'h4000);
        set_op(3, 16'h3800, 16'h3800);
        for (int k = 0; k < 5; k++) begin
            step(4'b1111);
            check("cont_grant", req_ready, 32'd1 << (k % 4));
        end
        for (int k = 0; k < 5; k++) begin
            step(4'b0000);
            check("cont_rsp_valid", rsp_valid, 1);
            check("cont_rsp_id", rsp_id, k % 4);
            check("cont_result", rsp_result, exp_res[k % 4]);
        end
        step(4'b0000);
        check("cont_rsp_end", rsp_valid, 0);

        // Drain with 3 ops in flight, ptr 1
        step(4'b0111);
        check("drain_g0", req_ready, 4'b0010);
        step(4'b0111);
        check("drain_g1", req_ready, 4'b0100);
        step(4'b0111);
        check("drain_g2", req_ready, 4'b0001);
        step(4'b0000);
        drain_req = 1'b1;
        check("drain_done_early", drain_done, 0);
        for (int k = 4; k < 8; k++) begin
            step(4'b1111);
            check("drain_ready_off", req_ready, 0);
            check("drain_done_wait", drain_done, 0);
            check("drain_rsp_valid", rsp_valid, (k >= 5) ? 1 : 0);
            if (k >= 5) check("drain_rsp_id", rsp_id, exp_drain_id[k-5]);
        end
        step(4'b1111);
        check("drain_done_rise", drain_done, 1);
        check("drain_busy", busy, 0);
        check("drain_ready_off2", req_ready, 0);
        step(4'b1111);
        check("drain_done_hold", drain_done, 1);
        drain_req = 1'b0;
        step(4'b1111);
        check("drain_resume", req_ready, 4'b0010);
        repeat (4) step(4'b0000);
        step(4'b0000);
        check("drain_resume_rsp", rsp_valid, 1);
        check("drain_resume_id", rsp_id, 1);

        // Sparse: ptr 2 -> 3, then requester 2 alone at ptr 3 wraps
        step(4'b0100);
        check("sparse_g0", req_ready, 4'b0100);
        step(4'b0100);
        check("sparse_wrap", req_ready, 4'b0100);
        step(4'b1111);
        check("sparse_ptr3", req_ready, 4'b1000);
        step(4'b0000);
        step(4'b0000);
        step(4'b0000);
        check("sparse_rsp0", rsp_id, 2);
        step(4'b0000);
        check("sparse_rsp1", rsp_id, 2);
        step(4'b0000);
        check("sparse_rsp2", rsp_id, 3);
        check("sparse_rsp2_valid", rsp_valid, 1);

        // Async reset with 2 ops in flight
        step(4'b0011);
        check("arst_g0", req_ready, 4'b0001);
        step(4'b0011);
        check("arst_g1", req_ready, 4'b0010);
        step(4'b0000);
        check("arst_busy_pre", busy, 1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy_now", busy, 0);
        check("arst_add_valid", add_valid, 0);
        step(4'b0000);
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            step(4'b0000);
            check("arst_no_rsp", rsp_valid, 0);
        end
        check("arst_busy", busy, 0);
        check("arst_perf_ops", perf_ops, 0);
        step(4'b1111);
        check("arst_ptr0", req_ready, 4'b0001);
        step(4'b0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
